mac_ctrl: RTL

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl_pkg.sv | 27 ++
 rtl/mac_ctrl_cnt.sv | 32 +++
 rtl/mac_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array load/result controller: FSM states,
// load-port mode encodings and the counter-width helper.
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_ADDR,
      LOAD_W,
      LOAD_D,
      WAIT_RES,
      DONE
   } state_t;

   localparam logic MODE_WEIGHT = 1'b1;
   localparam logic MODE_DATA   = 1'b0;

   // Bits needed to encode values 0..value-1 (0 when value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_ctrl_cnt.sv
// Loadable, clearable up-counter with a terminal flag (count == term_val).
// Clear has priority over load, load over increment.
module mac_ctrl_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic [WIDTH-1:0] term_val,
   output logic             term
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

   assign term = (count == term_val);

endmodule

// File: rtl/mac_ctrl.sv
// Job controller for an N x N systolic MAC array: streams weights/data into the
// array load port and forwards N results. Optional watchdog: MAC_CTRL_TIMEOUT_EN.
module mac_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int W       = 8,
   parameter int N       = 2,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         cmd_v_i,
   input  logic         cmd_load_w_i,
   output logic         cmd_ready_o,
   input  logic         in_v_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         mac_data_v_o,
   output logic         mac_data_mode_o,
   output logic         mac_data_rst_addr_o,
   output logic [W-1:0] mac_data_o,
   input  logic         mac_result_v_i,
   input  logic [W-1:0] mac_result_i,
   output logic         out_v_o,
   output logic [W-1:0] out_data_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   localparam int NN = N * N;
   localparam int BW = clog2(NN + 1);
   localparam int RW = clog2(N + 1);
   localparam logic [BW-1:0] BEAT_LAST_W = BW'(NN - 1);
   localparam logic [BW-1:0] BEAT_LAST_D = BW'(N - 1);
   localparam logic [RW-1:0] RES_LAST    = RW'(N - 1);

   state_t       state;
   logic         load_w_reg;
   logic         rst_addr_reg;
   logic         mac_v_reg;
   logic         mac_mode_reg;
   logic [W-1:0] mac_data_reg;
   logic         out_v_reg;
   logic [W-1:0] out_data_reg;
   logic         done_reg;

   logic          loading;
   logic          beat_acc;
   logic          beat_term;
   logic          last_beat;
   logic [BW-1:0] beat_term_val;
   logic          res_acc;
   logic          res_term;
   logic          last_res;

   assign loading       = (state == LOAD_W) || (state == LOAD_D);
   assign in_ready_o    = ena & loading;
   assign cmd_ready_o   = ena & (state == IDLE);
   assign beat_acc      = in_v_i & in_ready_o;
   assign last_beat     = beat_acc & beat_term;
   assign beat_term_val = (state == LOAD_W) ? BEAT_LAST_W : BEAT_LAST_D;
   assign res_acc       = ena & mac_result_v_i & (state == WAIT_RES);
   assign last_res      = res_acc & res_term;

   // Clearing whenever the FSM is outside a load state (or on its last beat)
   // gives a fresh count on every entry to LOAD_W and LOAD_D.
   mac_ctrl_cnt #(.WIDTH(BW)) u_beat_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (ena & (~loading | last_beat)),
      .load     (1'b0),
      .load_val ('0),
      .inc      (beat_acc),
      .term_val (beat_term_val),
      .term     (beat_term)
   );

   mac_ctrl_cnt #(.WIDTH(RW)) u_res_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (ena & ((state != WAIT_RES) | last_res)),
      .load     (1'b0),
      .load_val ('0),
      .inc      (res_acc),
      .term_val (RES_LAST),
      .term     (res_term)
   );

`ifdef MAC_CTRL_TIMEOUT_EN
   localparam int TW = clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   logic wd_inc;
   logic wd_term;
   logic wd_expire;
   logic err_reg;

   // Expires after TIMEOUT consecutive result-free cycles in WAIT_RES.
   assign wd_inc    = ena & (state == WAIT_RES) & ~res_acc;
   assign wd_expire = wd_inc & wd_term;

   mac_ctrl_cnt #(.WIDTH(TW)) u_wd_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (ena & ((state != WAIT_RES) | res_acc)),
      .load     (1'b0),
      .load_val ('0),
      .inc      (wd_inc),
      .term_val (WD_LAST),
      .term     (wd_term)
   );

   assign err_o = ena & err_reg;
`else
   assign err_o = 1'b0;
`endif

   // With ena low every register holds; a pulse captured just before the freeze
   // is masked at the outputs and presented once when ena returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         load_w_reg   <= 1'b0;
         rst_addr_reg <= 1'b0;
         mac_v_reg    <= 1'b0;
         mac_mode_reg <= MODE_DATA;
         mac_data_reg <= '0;
         out_v_reg    <= 1'b0;
         out_data_reg <= '0;
         done_reg     <= 1'b0;
`ifdef MAC_CTRL_TIMEOUT_EN
         err_reg      <= 1'b0;
`endif
      end else if (ena) begin
         rst_addr_reg <= 1'b0;
         mac_v_reg    <= 1'b0;
         out_v_reg    <= 1'b0;
         done_reg     <= 1'b0;
`ifdef MAC_CTRL_TIMEOUT_EN
         err_reg      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cmd_v_i) begin
                  load_w_reg   <= cmd_load_w_i;
                  rst_addr_reg <= 1'b1;
                  state        <= RST_ADDR;
               end
            end
            RST_ADDR: begin
               state <= load_w_reg ? LOAD_W : LOAD_D;
            end
            LOAD_W: begin
               if (beat_acc) begin
                  mac_v_reg    <= 1'b1;
                  mac_mode_reg <= MODE_WEIGHT;
                  mac_data_reg <= in_data_i;
                  if (beat_term) state <= LOAD_D;
               end
            end
            LOAD_D: begin
               if (beat_acc) begin
                  mac_v_reg    <= 1'b1;
                  mac_mode_reg <= MODE_DATA;
                  mac_data_reg <= in_data_i;
                  if (beat_term) state <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (res_acc) begin
                  out_v_reg    <= 1'b1;
                  out_data_reg <= mac_result_i;
                  if (res_term) begin
                     done_reg <= 1'b1;
                     state    <= DONE;
                  end
               end
`ifdef MAC_CTRL_TIMEOUT_EN
               else if (wd_expire) begin
                  err_reg <= 1'b1;
                  state   <= IDLE;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign mac_data_v_o        = ena & mac_v_reg;
   assign mac_data_rst_addr_o = ena & rst_addr_reg;
   assign mac_data_mode_o     = mac_mode_reg;
   assign mac_data_o          = mac_data_reg;
   assign out_v_o             = ena & out_v_reg;
   assign out_data_o          = out_data_reg;
   assign busy_o              = (state != IDLE);
   assign done_o              = ena & done_reg;

endmodule
